fft_demux_sched: RTL and testbench



---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_demux_sched.sv | 121 ++++++++++++
 tb/tb_fft_demux_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state type and bit-reversal helper for the FFT sample path.
package fft_pkg;

    localparam int FFT_LOG2_N = 11;
    localparam int FFT_N      = 2 ** FFT_LOG2_N;
    localparam int FFT_SEL0_W = 4;
    localparam int FFT_SEL1_W = 3;
    localparam int FFT_SEL2_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    // Bit-reverse a full-length bin index; also used by the output-side unload logic.
    function automatic logic [FFT_LOG2_N-1:0] bit_rev(input logic [FFT_LOG2_N-1:0] v);
        logic [FFT_LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_LOG2_N; i++) begin
            r[i] = v[FFT_LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_demux_sched.sv
// Input-side scheduler for the FFT demux tree: counts samples in a frame,
// issues per-sample bin selects one cycle later and holds the source off
// while a full frame waits for the FFT engine to release the buffer.
module fft_demux_sched
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LOG2_N      = FFT_LOG2_N,
    parameter int SEL0_W      = FFT_SEL0_W,
    parameter int SEL1_W      = FFT_SEL1_W,
    parameter int SEL2_W      = FFT_SEL2_W,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  buf_release,
    output logic                  dmx_valid,
    output logic [DATA_WIDTH-1:0] dmx_data,
    output logic [SEL0_W-1:0]     dmx_sel0,
    output logic [SEL1_W-1:0]     dmx_sel1,
    output logic [SEL2_W-1:0]     dmx_sel2,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long,
    output logic [15:0]           frame_cnt
);

    // The three select fields must tile the bin index exactly.
    if (SEL0_W + SEL1_W + SEL2_W != LOG2_N) begin : g_bad_split
        $error("fft_demux_sched: SEL0_W+SEL1_W+SEL2_W must equal LOG2_N");
    end

    localparam logic [LOG2_N-1:0] CNT_MAX = {LOG2_N{1'b1}};

    sched_state_t        r_state;
    sched_state_t        w_state_next;
    logic [LOG2_N-1:0]   r_cnt;
    logic [LOG2_N-1:0]   w_rev;
    logic [LOG2_N-1:0]   w_bin;
    logic                w_accept;
    logic                w_last_beat;

    // Ready depends only on state and enable; forced low while reset is held.
    assign s_ready     = en & (r_state == FILL) & ~rst;
    assign w_accept    = s_valid & s_ready;
    assign w_last_beat = (r_cnt == CNT_MAX);

    // Bit-reversed view of the sample count, wired per bit.
    for (genvar gi = 0; gi < LOG2_N; gi++) begin : g_rev
        assign w_rev[gi] = r_cnt[LOG2_N-1-gi];
    end

    assign w_bin = BIT_REVERSE ? w_rev : r_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a full frame parks in HOLD until the engine releases the buffer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_accept && w_last_beat) w_state_next = HOLD;
            HOLD:    if (buf_release)             w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // Sample counter: wraps at frame end and restarts on an early s_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last_beat || s_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LOG2_N'(1);
            end
        end
    end

    // Registered demux outputs and status pulses, one cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmx_valid  <= 1'b0;
            dmx_data   <= '0;
            dmx_sel0   <= '0;
            dmx_sel1   <= '0;
            dmx_sel2   <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            dmx_valid  <= w_accept;
            frame_done <= w_accept & w_last_beat;
            err_long   <= w_accept & w_last_beat & ~s_last;
            err_short  <= w_accept & ~w_last_beat & s_last;
            if (w_accept) begin
                dmx_data <= s_data;
                dmx_sel0 <= w_bin[LOG2_N-1 -: SEL0_W];
                dmx_sel1 <= w_bin[SEL2_W +: SEL1_W];
                dmx_sel2 <= w_bin[SEL2_W-1:0];
            end
            if (w_accept && w_last_beat) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_demux_sched.sv
// Bench for fft_demux_sched: a 16-bin natural-order instance for the frame,
// hold, short/long and reset sequences, plus a default bit-reversed instance.
module tb_fft_demux_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: LOG2_N=4, natural order
    logic        a_en = 1'b0, a_valid = 1'b0, a_last = 1'b0, a_release = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic        a_ready, a_dvalid, a_fd, a_es, a_el;
    logic [7:0]  a_ddata;
    logic [0:0]  a_sel0, a_sel1;
    logic [1:0]  a_sel2;
    logic [15:0] a_fcnt;

    // Instance B: defaults, bit-reversed
    logic        b_en = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_release = 1'b0;
    logic [7:0]  b_data = 8'h00;
    logic        b_ready, b_dvalid, b_fd, b_es, b_el;
    logic [7:0]  b_ddata;
    logic [3:0]  b_sel0;
    logic [2:0]  b_sel1;
    logic [3:0]  b_sel2;
    logic [15:0] b_fcnt;

    fft_demux_sched #(
        .DATA_WIDTH(8), .LOG2_N(4), .SEL0_W(1), .SEL1_W(1), .SEL2_W(2), .BIT_REVERSE(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .s_valid(a_valid), .s_ready(a_ready),
        .s_data(a_data), .s_last(a_last), .buf_release(a_release),
        .dmx_valid(a_dvalid), .dmx_data(a_ddata), .dmx_sel0(a_sel0), .dmx_sel1(a_sel1),
        .dmx_sel2(a_sel2), .frame_done(a_fd), .err_short(a_es), .err_long(a_el),
        .frame_cnt(a_fcnt)
    );

    fft_demux_sched #(
        .DATA_WIDTH(8), .LOG2_N(11), .SEL0_W(4), .SEL1_W(3), .SEL2_W(4), .BIT_REVERSE(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .s_last(b_last), .buf_release(b_release),
        .dmx_valid(b_dvalid), .dmx_data(b_ddata), .dmx_sel0(b_sel0), .dmx_sel1(b_sel1),
        .dmx_sel2(b_sel2), .frame_done(b_fd), .err_short(b_es), .err_long(b_el),
        .frame_cnt(b_fcnt)
    );

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  bin;
        logic        fd;
        logic        es;
        logic        el;
        logic [15:0] fcnt;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] s0;
        logic [2:0] s1;
        logic [3:0] s2;
    } bexp_t;

    exp_t        q[$];
    bexp_t       bq[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_fcnt = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    // Scoreboard side: pops one expected record per issued beat.
    task automatic monitor();
        exp_t  e;
        bexp_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (a_dvalid) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL a_unexpected_valid: dmx_valid=1 with no beat outstanding (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        check("a_data", 32'(a_ddata), 32'(e.data));
                        check("a_bin", 32'({a_sel0, a_sel1, a_sel2}), 32'(e.bin));
                        check("a_flags{done,short,long}", 32'({a_fd, a_es, a_el}),
                              32'({e.fd, e.es, e.el}));
                        check("a_frame_cnt", 32'(a_fcnt), 32'(e.fcnt));
                    end
                end else if (a_fd || a_es || a_el) begin
                    check("a_stray_pulse", 32'({a_fd, a_es, a_el}), 32'd0);
                end
                if (b_dvalid) begin
                    if (bq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL b_unexpected_valid: dmx_valid=1 with no beat outstanding (t=%0t)", $time);
                    end else begin
                        b = bq.pop_front();
                        check("b_data", 32'(b_ddata), 32'(b.data));
                        check("b_sel0", 32'(b_sel0), 32'(b.s0));
                        check("b_sel1", 32'(b_sel1), 32'(b.s1));
                        check("b_sel2", 32'(b_sel2), 32'(b.s2));
                        check("b_flags", 32'({b_fd, b_es, b_el}), 32'd0);
                    end
                end
            end
        end
    endtask

    // Offer one beat to instance A until accepted; gaps randomises valid and enable.
    task automatic send(input logic [7:0] d, input logic l, input logic [3:0] bin,
                        input logic fd, input logic es, input logic el, input bit gaps);
        int   tries;
        bit   done;
        exp_t e;
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            a_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_en    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_data  = (gaps && !a_valid) ? 8'($urandom) : d;
            a_last  = l;
            @(negedge clk);
            check("a_s_ready", 32'(a_ready), 32'(a_en));
            if (a_valid && a_en) begin
                if (fd) exp_fcnt = exp_fcnt + 16'd1;
                e = '{d, bin, fd, es, el, exp_fcnt};
                q.push_back(e);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 40) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_accept_timeout: beat %0h not accepted in 40 cycles", d);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            a_valid   = 1'b0;
            a_last    = 1'b0;
            a_release = 1'b0;
            a_en      = 1'b1;
            @(negedge clk);
        end
    endtask

    // Hold s_valid high while the frame is parked; nothing may be accepted.
    task automatic hold_check(input int n, input logic [15:0] fcnt_req);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            a_valid = 1'b1;
            a_en    = 1'b1;
            a_last  = 1'b0;
            @(negedge clk);
            check("hold_s_ready", 32'(a_ready), 32'd0);
            if (k == 0) check("hold_frame_cnt", 32'(a_fcnt), 32'(fcnt_req));
        end
    endtask

    task automatic release_pulse();
        @(posedge clk);
        #1;
        a_valid   = 1'b0;
        a_release = 1'b1;
        @(posedge clk);
        #1;
        a_release = 1'b0;
        @(negedge clk);
        check("release_s_ready", 32'(a_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] bin;
        logic       fd;
        logic       es;
        logic       el;
    } vec_t;

    vec_t  nat_tab[16];
    vec_t  short_tab[6];
    bexp_t brev_tab[4];

    initial begin
        bexp_t be;

        // Stimulus/expectation tables
        for (int i = 0; i < 16; i++) begin
            nat_tab[i] = '{8'(8'hA0 + i), (i == 15), 4'(i), (i == 15), 1'b0, 1'b0};
        end
        for (int i = 0; i < 6; i++) begin
            short_tab[i] = '{8'(8'h40 + i), (i == 5), 4'(i), 1'b0, (i == 5), 1'b0};
        end
        brev_tab[0] = '{8'h11, 4'd0,  3'd0, 4'd0};
        brev_tab[1] = '{8'h22, 4'd8,  3'd0, 4'd0};
        brev_tab[2] = '{8'h33, 4'd4,  3'd0, 4'd0};
        brev_tab[3] = '{8'h44, 4'd12, 3'd0, 4'd0};

        fork
            monitor();
        join_none

        // Reset state, with enable already high
        a_en = 1'b1;
        b_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_s_ready", 32'(a_ready), 32'd0);
        check("rst_b_s_ready", 32'(b_ready), 32'd0);
        check("rst_a_outputs", 32'({a_dvalid, a_fd, a_es, a_el, a_ddata}), 32'd0);
        check("rst_a_frame_cnt", 32'(a_fcnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_en = 1'b0;

        // Natural order, back-to-back full frame
        for (int i = 0; i < 16; i++) begin
            send(nat_tab[i].data, nat_tab[i].last, nat_tab[i].bin,
                 nat_tab[i].fd, nat_tab[i].es, nat_tab[i].el, 1'b0);
        end
        hold_check(10, 16'd1);
        release_pulse();

        // Release while filling is ignored
        @(posedge clk);
        #1;
        a_release = 1'b1;
        @(posedge clk);
        #1;
        a_release = 1'b0;

        // Short frame: s_last on beat 5
        for (int i = 0; i < 6; i++) begin
            send(short_tab[i].data, short_tab[i].last, short_tab[i].bin,
                 short_tab[i].fd, short_tab[i].es, short_tab[i].el, 1'b0);
        end
        idle(1);
        check("short_frame_cnt", 32'(a_fcnt), 32'd1);

        // Long frame with backpressure: starts at bin 0, no s_last anywhere
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), 1'b0, 4'(i), (i == 15), 1'b0, (i == 15), 1'b1);
        end
        hold_check(4, 16'd2);
        release_pulse();

        // Reset in the middle of a frame
        for (int i = 0; i < 7; i++) begin
            send(8'(8'h30 + i), 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_dmx_valid", 32'(a_dvalid), 32'd0);
        check("midrst_dmx_data", 32'(a_ddata), 32'd0);
        check("midrst_dmx_sel", 32'({a_sel0, a_sel1, a_sel2}), 32'd0);
        check("midrst_frame_cnt", 32'(a_fcnt), 32'd0);
        check("midrst_s_ready", 32'(a_ready), 32'd0);
        q.delete();
        exp_fcnt = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h5A, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("postrst_frame_cnt", 32'(a_fcnt), 32'd0);

        // Bit-reversed order on the default-size instance
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            b_en    = 1'b1;
            b_valid = 1'b1;
            b_data  = brev_tab[i].data;
            @(negedge clk);
            check("b_s_ready", 32'(b_ready), 32'd1);
            be = brev_tab[i];
            bq.push_back(be);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        idle(3);
        check("b_frame_cnt", 32'(b_fcnt), 32'd0);
        check("a_scoreboard_drained", 32'(q.size()), 32'd0);
        check("b_scoreboard_drained", 32'(bq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
